mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single external SPI memory controller between the instruction-fetch unit and the load/store unit of the RV32E core.
- Sequences the controller's level handshake: raise start_request, wait for request_done, drop start_request, then idle-gap.
- Latches each requester's command at grant and returns the read data into per-port holding registers.

Parameters:
- MIN_GAP_CYCLES, 1: cycles mem_start_request stays low between downstream transactions; values below 1 are treated as 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- i_req  input  1  fetch request level; held until i_done
- i_addr  input  32  fetch address
- i_num_bytes  input  3  fetch byte count, 1..4
- i_done  output  1  fetch complete
- i_data  output  32  fetch read data
- d_req  input  1  load/store request level; held until d_done
- d_addr  input  32  load/store address
- d_num_bytes  input  3  byte count, 1..4
- d_is_write  input  1  1 = store
- d_wdata  input  32  store data
- d_done  output  1  load/store complete
- d_rdata  output  32  load read data
- mem_start_request  output  1  to controller start_request
- mem_target_address  output  32  to controller
- mem_num_bytes  output  3  to controller
- mem_is_write  output  1  to controller
- mem_write_value  output  32  to controller
- mem_request_done  input  1  from controller
- mem_target_data  input  32  from controller
- busy  output  1  state is not IDLE
- owner  output  1  current/last grant: 0 = fetch, 1 = data

Behaviour:
- Reset:
  - Applied when rst_n is low at a clk edge. Takes effect at that edge even mid-transaction.
  - All outputs go to 0, state goes to IDLE, and the gap counter is cleared.
  - Dropping mem_start_request aborts the controller.
- States:
  - IDLE: if d_req or i_req is high, grant and latch the winner's addr, num_bytes, is_write and wdata into command registers, then go to ISSUE.
    - Without the optional feature, d_req wins whenever both are high in the same cycle.
    - Fetch grants force mem_is_write to 0.
    - num_bytes above 4 is clamped to 4; 0 is forwarded unchanged.
  - ISSUE: mem_start_request is 1 and the mem_* command outputs come from the command registers. On the edge where mem_request_done is 1:
    - Latch mem_target_data into the owner's data register (i_data or d_rdata). Stores also latch it, and the value is don't-care.
    - Set mem_start_request to 0.
    - If the owner's req is still 1, set owner done to 1 and go to RESPOND; otherwise go to GAP.
  - RESPOND: owner done stays 1 while owner req is 1. When owner req is sampled 0, done goes to 0 and the state goes to GAP.
  - GAP: mem_start_request stays 0. The counter loads MIN_GAP_CYCLES on entry and decrements each cycle; at 1 the state goes to IDLE.
- Latency:
  - A req sampled high in IDLE at edge N gives mem_start_request = 1 after edge N.
  - mem_request_done sampled at edge M gives done = 1 and mem_start_request = 0 after edge M.
- Command capture: changes to the owner's addr, num_bytes or wdata after grant are ignored until the next grant.
- Abort by requester: if the owner's req drops while in ISSUE, the downstream transaction still runs to completion, so stores are never truncated. No done is raised and the state goes to GAP.
- Non-owner: its req is ignored until IDLE; its done stays 0.
- Data registers: hold their value until overwritten by a later completion of the same port.
- busy: 1 in ISSUE, RESPOND and GAP.
- owner: updated at grant; holds its value in IDLE.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both reqs are high in IDLE, the port not granted last wins. The last-granted register resets to fetch, so data wins the first tie.
- Undefined: fixed priority, data over fetch; fetch can starve under continuous d_req.

Test Plan:
- Fetch only: i_req=1, i_addr=0x00000100, i_num_bytes=4; model returns 0xDEADBEEF with mem_request_done in cycle 20 -> mem_start_request high cycles 1-20, mem_num_bytes=4, mem_is_write=0, i_data=0xDEADBEEF with i_done=1 from cycle 21 until i_req drops, then mem_start_request low at least 1 cycle.
- Store: d_req=1, d_is_write=1, d_addr=0x01000010, d_wdata=0x12345678, d_num_bytes=4 -> mem_is_write=1, mem_write_value=0x12345678, mem_target_address=0x01000010, d_done after mem_request_done.
- Tie: i_req and d_req rise in the same cycle -> data served first. Fetch is served after the GAP, and i_addr changes during the data transaction are not observed on mem_target_address.
- Requester abort: drop d_req mid-ISSUE -> mem_start_request stays 1 until mem_request_done, d_done never 1, busy returns 0 after the GAP.
- Reset mid-ISSUE: rst_n=0 for 1 cycle -> next cycle all outputs 0, state IDLE, and a later request proceeds normally.
- MEM_ARB_ROUND_ROBIN_EN defined, both reqs held continuously for 4 transactions -> grant order is data, fetch, data, fetch; undefined -> data on all four.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SPI memory controller between the fetch port and the load/store port.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN alternates tie grants instead of fixed data priority.
module mem_arbiter #(
    parameter int MIN_GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_num_bytes,
    output logic        i_done,
    output logic [31:0] i_data,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_num_bytes,
    input  logic        d_is_write,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,

    output logic        mem_start_request,
    output logic [31:0] mem_target_address,
    output logic [2:0]  mem_num_bytes,
    output logic        mem_is_write,
    output logic [31:0] mem_write_value,
    input  logic        mem_request_done,
    input  logic [31:0] mem_target_data,

    output logic        busy,
    output logic        owner
);

    localparam logic [31:0] GAP_LOAD = (MIN_GAP_CYCLES < 1) ? 32'd1 : 32'(MIN_GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESPOND,
        GAP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] gap_cnt;
    logic [31:0] gap_cnt_next;
    logic        owner_next;
    logic        grant_data;
    logic        owner_req;
    logic        start_next;
    logic        i_done_next;
    logic        d_done_next;
    logic [31:0] addr_next;
    logic [2:0]  num_bytes_next;
    logic        is_write_next;
    logic [31:0] wdata_next;
    logic [31:0] i_data_next;
    logic [31:0] d_rdata_next;

    function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
        return (n > 3'd4) ? 3'd4 : n;
    endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // owner doubles as the last-granted record; it resets to fetch, so data wins the first tie
    assign grant_data = d_req && (!i_req || !owner);
`else
    assign grant_data = d_req;
`endif

    assign owner_req = owner ? d_req : i_req;
    assign busy      = (state != IDLE);

    always_comb begin
        state_next     = state;
        gap_cnt_next   = gap_cnt;
        owner_next     = owner;
        start_next     = mem_start_request;
        i_done_next    = i_done;
        d_done_next    = d_done;
        addr_next      = mem_target_address;
        num_bytes_next = mem_num_bytes;
        is_write_next  = mem_is_write;
        wdata_next     = mem_write_value;
        i_data_next    = i_data;
        d_rdata_next   = d_rdata;

        case (state)
            IDLE: begin
                if (d_req || i_req) begin
                    owner_next = grant_data;
                    start_next = 1'b1;
                    state_next = ISSUE;
                    if (grant_data) begin
                        addr_next      = d_addr;
                        num_bytes_next = clamp_bytes(d_num_bytes);
                        is_write_next  = d_is_write;
                        wdata_next     = d_wdata;
                    end else begin
                        addr_next      = i_addr;
                        num_bytes_next = clamp_bytes(i_num_bytes);
                        is_write_next  = 1'b0;
                        wdata_next     = 32'd0;
                    end
                end
            end

            // The downstream transaction always completes, even if the requester gave up
            ISSUE: begin
                if (mem_request_done) begin
                    start_next = 1'b0;
                    if (owner) begin
                        d_rdata_next = mem_target_data;
                    end else begin
                        i_data_next = mem_target_data;
                    end
                    if (owner_req) begin
                        if (owner) begin
                            d_done_next = 1'b1;
                        end else begin
                            i_done_next = 1'b1;
                        end
                        state_next = RESPOND;
                    end else begin
                        gap_cnt_next = GAP_LOAD;
                        state_next   = GAP;
                    end
                end
            end

            RESPOND: begin
                if (!owner_req) begin
                    i_done_next  = 1'b0;
                    d_done_next  = 1'b0;
                    gap_cnt_next = GAP_LOAD;
                    state_next   = GAP;
                end
            end

            GAP: begin
                if (gap_cnt <= 32'd1) begin
                    gap_cnt_next = 32'd0;
                    state_next   = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt - 32'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            gap_cnt            <= 32'd0;
            owner              <= 1'b0;
            mem_start_request  <= 1'b0;
            i_done             <= 1'b0;
            d_done             <= 1'b0;
            mem_target_address <= 32'd0;
            mem_num_bytes      <= 3'd0;
            mem_is_write       <= 1'b0;
            mem_write_value    <= 32'd0;
            i_data             <= 32'd0;
            d_rdata            <= 32'd0;
        end else begin
            state              <= state_next;
            gap_cnt            <= gap_cnt_next;
            owner              <= owner_next;
            mem_start_request  <= start_next;
            i_done             <= i_done_next;
            d_done             <= d_done_next;
            mem_target_address <= addr_next;
            mem_num_bytes      <= num_bytes_next;
            mem_is_write       <= is_write_next;
            mem_write_value    <= wdata_next;
            i_data             <= i_data_next;
            d_rdata            <= d_rdata_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard of expected downstream commands and responses.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [2:0]  i_num_bytes;
    logic        i_done;
    logic [31:0] i_data;
    logic        d_req;
    logic [31:0] d_addr;
    logic [2:0]  d_num_bytes;
    logic        d_is_write;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_start_request;
    logic [31:0] mem_target_address;
    logic [2:0]  mem_num_bytes;
    logic        mem_is_write;
    logic [31:0] mem_write_value;
    logic        mem_request_done;
    logic [31:0] mem_target_data;
    logic        busy;
    logic        owner;

    typedef struct {
        bit          port;
        logic [31:0] addr;
        logic [2:0]  nb;
        bit          wr;
        logic [31:0] wdata;
        int          len;
    } cmd_t;

    typedef struct {
        bit          port;
        logic [31:0] data;
        bit          check_data;
    } rsp_t;

    typedef struct {
        int          lat;
        logic [31:0] data;
    } mdl_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    mdl_t mdl_q[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_req              (i_req),
        .i_addr             (i_addr),
        .i_num_bytes        (i_num_bytes),
        .i_done             (i_done),
        .i_data             (i_data),
        .d_req              (d_req),
        .d_addr             (d_addr),
        .d_num_bytes        (d_num_bytes),
        .d_is_write         (d_is_write),
        .d_wdata            (d_wdata),
        .d_done             (d_done),
        .d_rdata            (d_rdata),
        .mem_start_request  (mem_start_request),
        .mem_target_address (mem_target_address),
        .mem_num_bytes      (mem_num_bytes),
        .mem_is_write       (mem_is_write),
        .mem_write_value    (mem_write_value),
        .mem_request_done   (mem_request_done),
        .mem_target_data    (mem_target_data),
        .busy               (busy),
        .owner              (owner)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Queue one downstream transaction: the command the arbiter must issue, the
    // memory model's latency/data, and optionally the response the requester must get.
    task automatic expectTxn(input bit port, input logic [31:0] addr, input logic [2:0] nb,
                             input bit wr, input logic [31:0] wdata, input int lat,
                             input logic [31:0] rdata, input bit responds, input bit check_len);
        cmd_t c;
        mdl_t m;
        rsp_t r;
        c.port = port; c.addr = addr; c.nb = nb; c.wr = wr; c.wdata = wdata;
        c.len = check_len ? lat : 0;
        cmd_q.push_back(c);
        m.lat = lat; m.data = rdata;
        mdl_q.push_back(m);
        if (responds) begin
            r.port = port; r.data = rdata; r.check_data = !wr;
            rsp_q.push_back(r);
        end
    endtask

    task automatic applyStimulus(input bit port, input logic [31:0] addr, input logic [2:0] nb,
                                 input bit wr, input logic [31:0] wdata, input int hold,
                                 input int abort_after);
        int n;
        bit seen;
        @(negedge clk);
        if (port) begin
            d_req = 1'b1; d_addr = addr; d_num_bytes = nb; d_is_write = wr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr; i_num_bytes = nb;
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < TIMEOUT && !(abort_after > 0 && n >= abort_after)) begin
            @(negedge clk);
            n++;
            seen = port ? d_done : i_done;
        end
        if (abort_after == 0) begin
            checkOutput(port ? "d_done_seen" : "i_done_seen", 32'(seen), 32'd1);
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                checkOutput(port ? "d_done_hold" : "i_done_hold", 32'(port ? d_done : i_done), 32'd1);
            end
        end
        if (port) d_req = 1'b0;
        else      i_req = 1'b0;
    endtask

    task automatic checkResponse(input bit port);
        rsp_t r;
        checkOutput(port ? "d_rsp_pending" : "i_rsp_pending", 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            checkOutput("rsp_port", 32'(port), 32'(r.port));
            if (r.check_data) begin
                checkOutput(port ? "d_rdata" : "i_data", port ? d_rdata : i_data, r.data);
            end
        end
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (busy && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    // Controller model: holds mem_request_done for one cycle after the queued latency
    initial begin : memory_model
        bit          active;
        int          cnt;
        mdl_t        cur;
        active           = 1'b0;
        cnt              = 0;
        cur.lat          = 4;
        cur.data         = 32'd0;
        mem_request_done = 1'b0;
        mem_target_data  = 32'd0;
        forever begin
            @(negedge clk);
            mem_request_done = 1'b0;
            if (mem_start_request) begin
                if (!active) begin
                    active = 1'b1;
                    cnt    = 1;
                    if (mdl_q.size() != 0) cur = mdl_q.pop_front();
                    else begin cur.lat = 4; cur.data = 32'd0; end
                end else begin
                    cnt++;
                end
                if (cnt >= cur.lat) begin
                    mem_request_done = 1'b1;
                    mem_target_data  = cur.data;
                    active           = 1'b0;
                end
            end else begin
                active = 1'b0;
            end
        end
    end

    initial begin : monitor
        cmd_t cur;
        bit   have_cur;
        bit   prev_start;
        bit   prev_id;
        bit   prev_dd;
        int   len;
        have_cur   = 1'b0;
        prev_start = 1'b0;
        prev_id    = 1'b0;
        prev_dd    = 1'b0;
        len        = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_start_request && !prev_start) begin
                len = 1;
                checkOutput("cmd_pending", 32'(cmd_q.size() != 0), 32'd1);
                have_cur = (cmd_q.size() != 0);
                if (have_cur) begin
                    cur = cmd_q.pop_front();
                    checkOutput("owner", 32'(owner), 32'(cur.port));
                    checkOutput("mem_target_address", mem_target_address, cur.addr);
                    checkOutput("mem_num_bytes", 32'(mem_num_bytes), 32'(cur.nb));
                    checkOutput("mem_is_write", 32'(mem_is_write), 32'(cur.wr));
                    if (cur.wr) checkOutput("mem_write_value", mem_write_value, cur.wdata);
                    checkOutput("busy_issue", 32'(busy), 32'd1);
                end
            end else if (mem_start_request) begin
                len++;
            end else if (prev_start && have_cur && cur.len != 0) begin
                checkOutput("start_len", 32'(len), 32'(cur.len));
            end
            if (i_done && !prev_id) checkResponse(1'b0);
            if (d_done && !prev_dd) checkResponse(1'b1);
            prev_start = mem_start_request;
            prev_id    = i_done;
            prev_dd    = d_done;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: actual=expired required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = 32'd0; i_num_bytes = 3'd0;
        d_req = 1'b0; d_addr = 32'd0; d_num_bytes = 3'd0; d_is_write = 1'b0; d_wdata = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_start", 32'(mem_start_request), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_owner", 32'(owner), 32'd0);
        checkOutput("rst_i_done", 32'(i_done), 32'd0);
        checkOutput("rst_d_done", 32'(d_done), 32'd0);
        checkOutput("rst_i_data", i_data, 32'd0);
        checkOutput("rst_d_rdata", d_rdata, 32'd0);
        rst_n = 1'b1;

        $display("[TB] fetch only");
        expectTxn(1'b0, 32'h0000_0100, 3'd4, 1'b0, 32'd0, 20, 32'hDEAD_BEEF, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0000_0100, 3'd4, 1'b0, 32'd0, 2, 0);
        checkOutput("fetch_start_low", 32'(mem_start_request), 32'd0);
        @(negedge clk);
        checkOutput("fetch_done_drop", 32'(i_done), 32'd0);
        checkOutput("fetch_gap_busy", 32'(busy), 32'd1);
        checkOutput("fetch_gap_start", 32'(mem_start_request), 32'd0);
        @(negedge clk);
        checkOutput("fetch_idle_busy", 32'(busy), 32'd0);
        checkOutput("fetch_owner_hold", 32'(owner), 32'd0);

        $display("[TB] store");
        expectTxn(1'b1, 32'h0100_0010, 3'd4, 1'b1, 32'h1234_5678, 6, 32'h7777_7777, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0100_0010, 3'd4, 1'b1, 32'h1234_5678, 1, 0);
        waitIdle("store_idle");
        checkOutput("i_data_hold", i_data, 32'hDEAD_BEEF);

        $display("[TB] byte count boundaries");
        expectTxn(1'b1, 32'h0100_0020, 3'd4, 1'b0, 32'd0, 3, 32'h55AA_0011, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0100_0020, 3'd7, 1'b0, 32'd0, 0, 0);
        expectTxn(1'b0, 32'h0000_0104, 3'd0, 1'b0, 32'd0, 2, 32'h0BAD_F00D, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0000_0104, 3'd0, 1'b0, 32'd0, 0, 0);
        waitIdle("bounds_idle");
        checkOutput("d_rdata_hold", d_rdata, 32'h55AA_0011);

        $display("[TB] tie");
        expectTxn(1'b1, 32'h2000_0040, 3'd2, 1'b1, 32'hA5A5_A5A5, 6, 32'h7777_7777, 1'b1, 1'b1);
        expectTxn(1'b0, 32'h0000_0200, 3'd4, 1'b0, 32'd0, 3, 32'h600D_C0DE, 1'b1, 1'b1);
        fork
            applyStimulus(1'b1, 32'h2000_0040, 3'd2, 1'b1, 32'hA5A5_A5A5, 0, 0);
            applyStimulus(1'b0, 32'h0000_0200, 3'd4, 1'b0, 32'd0, 0, 0);
            begin : tamper
                int n;
                n = 0;
                @(negedge clk);
                while (!mem_start_request && n < TIMEOUT) begin
                    @(negedge clk);
                    n++;
                end
                i_addr  = 32'hBADB_AD00;
                d_addr  = 32'hBADB_AD04;
                d_wdata = 32'hFFFF_FFFF;
                @(negedge clk);
                checkOutput("tie_addr_hold", mem_target_address, 32'h2000_0040);
                checkOutput("tie_wdata_hold", mem_write_value, 32'hA5A5_A5A5);
                checkOutput("tie_owner", 32'(owner), 32'd1);
                i_addr = 32'h0000_0200;
            end
        join
        waitIdle("tie_idle");

        $display("[TB] requester abort");
        expectTxn(1'b1, 32'h0100_0030, 3'd4, 1'b1, 32'hCAFE_BABE, 8, 32'h7777_7777, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0100_0030, 3'd4, 1'b1, 32'hCAFE_BABE, 0, 3);
        checkOutput("abort_start_held", 32'(mem_start_request), 32'd1);
        waitIdle("abort_busy_clear");
        checkOutput("abort_no_done", 32'(d_done), 32'd0);

        $display("[TB] reset mid-issue");
        expectTxn(1'b0, 32'h0000_0300, 3'd4, 1'b0, 32'd0, 10, 32'h1111_1111, 1'b0, 1'b0);
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0300; i_num_bytes = 3'd4;
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_start", 32'(mem_start_request), 32'd1);
        rst_n = 1'b0;
        i_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mid_rst_start", 32'(mem_start_request), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_addr", mem_target_address, 32'd0);
        checkOutput("mid_rst_nb", 32'(mem_num_bytes), 32'd0);
        checkOutput("mid_rst_i_data", i_data, 32'd0);
        checkOutput("mid_rst_d_rdata", d_rdata, 32'd0);
        expectTxn(1'b0, 32'h0000_0400, 3'd1, 1'b0, 32'd0, 2, 32'hCAFE_F00D, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0000_0400, 3'd1, 1'b0, 32'd0, 0, 0);
        waitIdle("post_rst_idle");

        $display("[TB] arbitration order");
`ifdef MEM_ARB_ROUND_ROBIN_EN
        expectTxn(1'b1, 32'h0000_2000, 3'd4, 1'b0, 32'd0, 3, 32'hD000_0000, 1'b1, 1'b1);
        expectTxn(1'b0, 32'h0000_3000, 3'd4, 1'b0, 32'd0, 3, 32'hF000_0000, 1'b1, 1'b1);
        expectTxn(1'b1, 32'h0000_2004, 3'd4, 1'b0, 32'd0, 3, 32'hD000_0001, 1'b1, 1'b1);
        expectTxn(1'b0, 32'h0000_3004, 3'd4, 1'b0, 32'd0, 3, 32'hF000_0001, 1'b1, 1'b1);
        fork
            begin
                applyStimulus(1'b1, 32'h0000_2000, 3'd4, 1'b0, 32'd0, 0, 0);
                applyStimulus(1'b1, 32'h0000_2004, 3'd4, 1'b0, 32'd0, 0, 0);
            end
            begin
                applyStimulus(1'b0, 32'h0000_3000, 3'd4, 1'b0, 32'd0, 0, 0);
                applyStimulus(1'b0, 32'h0000_3004, 3'd4, 1'b0, 32'd0, 0, 0);
            end
        join
`else
        for (int k = 0; k < 4; k++) begin
            expectTxn(1'b1, 32'h0000_2000 + 32'(4 * k), 3'd4, 1'b0, 32'd0, 3,
                      32'hD000_0000 + 32'(k), 1'b1, 1'b1);
        end
        expectTxn(1'b0, 32'h0000_3000, 3'd4, 1'b0, 32'd0, 3, 32'hF000_0000, 1'b1, 1'b1);
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    applyStimulus(1'b1, 32'h0000_2000 + 32'(4 * k), 3'd4, 1'b0, 32'd0, 0, 0);
                end
            end
            applyStimulus(1'b0, 32'h0000_3000, 3'd4, 1'b0, 32'd0, 0, 0);
        join
`endif
        waitIdle("order_idle");

        repeat (5) @(negedge clk);
        checkOutput("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        checkOutput("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
